// File: rtl/line_fifo_ctrl.sv
// Line-buffer ring controller: sequences pixel writes into LINE_NUM banks and retires lines on Cal pops.
// Write strobe is combinational (0-cycle latency); inReady drops when all banks hold complete lines.
module line_fifo_ctrl #(
  parameter int ADDRESS_WIDTH = 11,
  parameter int BUFFER_SIZE   = 3,
  parameter int LINE_NUM      = 4,
  parameter int BANK_WIDTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] inXNum,
  input  logic [ADDRESS_WIDTH-1:0] inYNum,
  input  logic                     inVS,
  input  logic                     dInEn,
  output logic                     inReady,
  output logic                     ramWrEn,
  output logic [BANK_WIDTH-1:0]    ramWrBank,
  output logic [ADDRESS_WIDTH-1:0] ramAddrIn,
  input  logic                     jmp1,
  input  logic                     jmp2,
  output logic [BUFFER_SIZE-1:0]   fifoNum,
  output logic [BANK_WIDTH-1:0]    rdBank0,
  output logic [BANK_WIDTH-1:0]    rdBank1,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [BUFFER_SIZE-1:0] LINES = BUFFER_SIZE'(LINE_NUM);

  logic [1:0]               state_q, state_d;
  logic [BANK_WIDTH-1:0]    wr_bank_q, wr_bank_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BUFFER_SIZE-1:0]   complete_q, complete_d;
  logic [BANK_WIDTH-1:0]    head_q, head_d;
  logic [ADDRESS_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;

  logic [BANK_WIDTH-1:0]    base_bank;
  logic [ADDRESS_WIDTH-1:0] base_addr;
  logic [ADDRESS_WIDTH-1:0] base_cnt;
  logic [BUFFER_SIZE-1:0]   base_complete;
  logic [BANK_WIDTH-1:0]    base_head;
  logic [BUFFER_SIZE-1:0]   req;
  logic [BUFFER_SIZE-1:0]   pop;
  logic                     accept;
  logic                     line_end;

  assign inReady = inVS | ((state_q == S_RUN) && (complete_q < LINES));
  assign ramWrEn = dInEn & inReady;

  // inVS restarts the frame in the same cycle, so a coincident pixel lands at bank 0 / address 0.
  assign base_bank     = inVS ? '0 : wr_bank_q;
  assign base_addr     = inVS ? '0 : addr_q;
  assign base_cnt      = inVS ? '0 : line_cnt_q;
  assign base_complete = inVS ? '0 : complete_q;
  assign base_head     = inVS ? '0 : head_q;

  assign ramWrBank = base_bank;
  assign ramAddrIn = base_addr;
  assign fifoNum   = complete_q + BUFFER_SIZE'(addr_q != '0);
  assign rdBank0   = head_q;
  assign rdBank1   = head_q + BANK_WIDTH'(1);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = base_bank;
    addr_d      = base_addr;
    line_cnt_d  = base_cnt;
    overflow_d  = inVS ? 1'b0 : overflow_q;
    underflow_d = inVS ? 1'b0 : underflow_q;
    accept      = dInEn & inReady;
    line_end    = accept && (base_addr == inXNum - ADDRESS_WIDTH'(1));
    req         = jmp2 ? BUFFER_SIZE'(2) : (jmp1 ? BUFFER_SIZE'(1) : '0);
    pop         = '0;

    if (inVS) begin
      state_d = S_RUN;
    end

    if (accept) begin
      if (line_end) begin
        addr_d     = '0;
        wr_bank_d  = base_bank + BANK_WIDTH'(1);
        line_cnt_d = base_cnt + ADDRESS_WIDTH'(1);
        if (base_cnt + ADDRESS_WIDTH'(1) == inYNum) begin
          state_d = S_DRAIN;
        end
      end else begin
        addr_d = base_addr + ADDRESS_WIDTH'(1);
      end
    end

    if (!inVS && (state_q == S_RUN) && dInEn && !inReady) begin
      overflow_d = 1'b1;
    end

    // Pops are limited to lines completed before this cycle's write.
    if (!inVS && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
      if (req > complete_q) begin
        pop         = complete_q;
        underflow_d = 1'b1;
      end else begin
        pop = req;
      end
    end

    complete_d = base_complete + BUFFER_SIZE'(line_end) - pop;
    head_d     = base_head + pop[BANK_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= '0;
      addr_q      <= '0;
      complete_q  <= '0;
      head_q      <= '0;
      line_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      addr_q      <= addr_d;
      complete_q  <= complete_d;
      head_q      <= head_d;
      line_cnt_q  <= line_cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_line_fifo_ctrl.sv
// Bench for line_fifo_ctrl: vector table, directed corner sequences and a random run against a queue model.
module tb_line_fifo_ctrl;
  localparam int AW = 11;
  localparam int BS = 3;
  localparam int LN = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] inXNum, inYNum;
  logic          inVS, dInEn, jmp1, jmp2;
  logic          inReady, ramWrEn, overflow, underflow;
  logic [BW-1:0] ramWrBank, rdBank0, rdBank1;
  logic [AW-1:0] ramAddrIn;
  logic [BS-1:0] fifoNum;

  line_fifo_ctrl #(.ADDRESS_WIDTH(AW), .BUFFER_SIZE(BS), .LINE_NUM(LN), .BANK_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .inXNum(inXNum), .inYNum(inYNum), .inVS(inVS), .dInEn(dInEn),
    .inReady(inReady), .ramWrEn(ramWrEn), .ramWrBank(ramWrBank), .ramAddrIn(ramAddrIn),
    .jmp1(jmp1), .jmp2(jmp2), .fifoNum(fifoNum), .rdBank0(rdBank0), .rdBank1(rdBank1),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame mode (0 idle, 1 run, 2 drain), pixel/line position, queue of completed lines.
  int m_mode, m_x, m_y, m_head, m_ovf, m_unf;
  int m_q[$];

  typedef struct {
    logic vs;
    logic en;
    int   addr;
    int   bank;
    int   fifo;
    int   wren;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic en, input logic j1, input logic j2);
    @(negedge clk);
    inVS = vs; dInEn = en; jmp1 = j1; jmp2 = j2;
    #2;
  endtask

  task automatic write_px(input int bank);
    m_x++;
    if (m_x == int'(inXNum)) begin
      m_x = 0;
      m_q.push_back(bank);
      m_y++;
      if (m_y == int'(inYNum)) m_mode = 2;
    end
  endtask

  // Compare the current cycle's outputs with the model, advance the model, then take the clock edge.
  task automatic tick();
    int n, rdy, bank, req, pop;
    n    = m_q.size();
    rdy  = (inVS || (m_mode == 1 && n < LN)) ? 1 : 0;
    bank = inVS ? 0 : (m_head + n) % LN;
    chk("m_ready", inReady, rdy);
    chk("m_wren", ramWrEn, (dInEn && rdy) ? 1 : 0);
    chk("m_bank", ramWrBank, bank);
    chk("m_addr", ramAddrIn, inVS ? 0 : m_x);
    chk("m_fifo", fifoNum, n + ((m_x != 0) ? 1 : 0));
    chk("m_rd0", rdBank0, m_head);
    chk("m_rd1", rdBank1, (m_head + 1) % LN);
    chk("m_ovf", overflow, m_ovf);
    chk("m_unf", underflow, m_unf);
    if (inVS) begin
      m_q.delete();
      m_head = 0; m_x = 0; m_y = 0; m_ovf = 0; m_unf = 0; m_mode = 1;
      if (dInEn) write_px(0);
    end else begin
      if (m_mode != 0) begin
        req = jmp2 ? 2 : (jmp1 ? 1 : 0);
        pop = (req > n) ? n : req;
        if (req > n) m_unf = 1;
        repeat (pop) void'(m_q.pop_front());
        m_head = (m_head + pop) % LN;
      end
      if (m_mode == 1 && dInEn) begin
        if (rdy != 0) write_px(bank);
        else m_ovf = 1;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; inVS = 1'b0; dInEn = 1'b1; jmp1 = 1'b0; jmp2 = 1'b0;
    inXNum = 8; inYNum = 6;
    m_mode = 0; m_x = 0; m_y = 0; m_head = 0; m_ovf = 0; m_unf = 0;

    tbl[0] = '{1'b1, 1'b1, 0, 0, 0, 1};
    for (int i = 1; i < 8; i++) tbl[i] = '{1'b0, 1'b1, i, 0, 1, 1};
    tbl[8] = '{1'b0, 1'b0, 0, 1, 1, 0};
    for (int i = 0; i < 3; i++) tbl[9 + i] = '{1'b0, 1'b1, i, 1, (i == 0) ? 1 : 2, 1};
    tbl[12] = '{1'b0, 1'b0, 3, 1, 2, 0};

    // Reset held with dInEn high.
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_ready", inReady, 0);
    chk("rst_wren", ramWrEn, 0);
    chk("rst_bank", ramWrBank, 0);
    chk("rst_addr", ramAddrIn, 0);
    chk("rst_fifo", fifoNum, 0);
    chk("rst_rd0", rdBank0, 0);
    chk("rst_rd1", rdBank1, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    rst = 1'b0;
    drive(0, 1, 0, 0);
    chk("idle_wren", ramWrEn, 0);
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].vs, tbl[i].en, 0, 0);
      chk("tbl_addr", ramAddrIn, tbl[i].addr);
      chk("tbl_bank", ramWrBank, tbl[i].bank);
      chk("tbl_fifo", fifoNum, tbl[i].fifo);
      chk("tbl_wren", ramWrEn, tbl[i].wren);
      tick();
    end

    // Fill all four banks, then offer one more pixel.
    repeat (21) begin drive(0, 1, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    chk("full_ready", inReady, 0);
    chk("full_fifo", fifoNum, 4);
    tick();
    drive(0, 1, 0, 0);
    chk("ovf_wren", ramWrEn, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_addr", ramAddrIn, 0);
    chk("ovf_bank", ramWrBank, 0);
    chk("ovf_fifo", fifoNum, 4);
    tick();

    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    chk("pop2_fifo", fifoNum, 2);
    chk("pop2_rd0", rdBank0, 2);
    chk("pop2_rd1", rdBank1, 3);
    chk("pop2_ready", inReady, 1);
    tick();

    // Lines 5 and 6 end the frame; drain with a wrapping head.
    repeat (16) begin drive(0, 1, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    chk("drain_ready", inReady, 0);
    chk("drain_fifo", fifoNum, 4);
    tick();
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 1);
    chk("drain_rd0_pre", rdBank0, 3);
    tick();
    drive(0, 0, 0, 0);
    chk("wrap_rd0", rdBank0, 1);
    chk("wrap_rd1", rdBank1, 2);
    chk("wrap_fifo", fifoNum, 1);
    tick();
    drive(1, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("vs_fifo", fifoNum, 1);
    chk("vs_addr", ramAddrIn, 1);
    chk("vs_ready", inReady, 1);
    chk("vs_rd0", rdBank0, 0);
    chk("vs_ovf_clr", overflow, 0);
    tick();

    // Pop with nothing complete, then pop on the cycle a line completes.
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    chk("unf_flag", underflow, 1);
    chk("unf_rd0", rdBank0, 0);
    tick();
    repeat (14) begin drive(0, 1, 0, 0); tick(); end
    drive(0, 1, 1, 0); tick();
    drive(0, 0, 0, 0);
    chk("simul_fifo", fifoNum, 1);
    chk("simul_rd0", rdBank0, 1);
    chk("simul_bank", ramWrBank, 2);
    tick();

    for (int c = 0; c < 4000; c++) begin
      logic vs;
      vs = ($urandom_range(0, 59) == 0);
      if (vs) begin
        #1;
        inXNum = AW'($urandom_range(1, 5));
        inYNum = AW'($urandom_range(1, 6));
      end
      drive(vs, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/line_fifo_ctrl.md
Name: line_fifo_ctrl

Overview:
- Controls the line-buffer RAM ring that feeds the bilinear scaling core (`Cal`).
- Sequences input-pixel writes into one of LINE_NUM physical line banks.
- Reports occupied line count (fifoNum) and the write address (ramAddrIn) that `Cal` uses for mode selection and read gating.
- Retires lines when `Cal` asserts jmp1/jmp2, and tracks frame boundaries on the input side.

Parameters:
- ADDRESS_WIDTH, 11, width of in-line pixel address and line-length ports.
- BUFFER_SIZE, 3, width of fifoNum; must hold LINE_NUM.
- LINE_NUM, 4, number of physical line banks (power of two, ≥2).
- BANK_WIDTH, 2, log2(LINE_NUM).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- inXNum  in  ADDRESS_WIDTH  pixels per input line (≥1)
- inYNum  in  ADDRESS_WIDTH  lines per input frame (≥1)
- inVS  in  1  input frame-start pulse
- dInEn  in  1  input pixel valid
- inReady  out  1  controller can accept a pixel this cycle
- ramWrEn  out  1  line-RAM write strobe
- ramWrBank  out  BANK_WIDTH  bank being written
- ramAddrIn  out  ADDRESS_WIDTH  write address within bank
- jmp1  in  1  `Cal` request: retire 1 line
- jmp2  in  1  `Cal` request: retire 2 lines
- fifoNum  out  BUFFER_SIZE  occupied lines: complete lines + 1 if a line is partially written
- rdBank0  out  BANK_WIDTH  head bank (row v)
- rdBank1  out  BANK_WIDTH  head+1 mod LINE_NUM (row v+1)
- overflow  out  1  sticky: pixel offered while not ready in RUN
- underflow  out  1  sticky: pop request exceeded complete lines

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and overrides everything, including mid-line or mid-frame.
- State machine: IDLE, RUN, DRAIN. Reset → IDLE.
  - IDLE→RUN on inVS.
  - RUN→DRAIN when the last pixel of line inYNum is written.
  - DRAIN→RUN on inVS.
  - inVS in RUN restarts the frame.
- inVS, any state: next cycle wrBank=0, ramAddrIn=0, complete=0, head=0, lineCnt=0, overflow=0, underflow=0.
  - A pixel with dInEn on the same cycle as inVS is written to bank 0, address 0. The next ramAddrIn is then 1.
  - Pops on the inVS cycle are ignored.
- Reset values:
  - inReady=0, ramWrEn=0, ramWrBank=0, ramAddrIn=0.
  - fifoNum=0, rdBank0=0, rdBank1=1.
  - overflow=0, underflow=0.
  - Internal complete=0, lineCnt=0.
- inReady = 1 only when state==RUN and complete<LINE_NUM (inVS cycle: 1).
- ramWrEn = dInEn & inReady, combinational. ramWrBank and ramAddrIn are registered pointers presented in the same cycle, so write latency is 0.
- Accepted pixel:
  - If ramAddrIn==inXNum-1: ramAddrIn←0, wrBank←wrBank+1 mod LINE_NUM, complete+1, lineCnt+1.
  - Otherwise ramAddrIn+1.
- Overflow: dInEn while !inReady in RUN sets overflow. The pixel is dropped and no pointer moves. dInEn in IDLE or DRAIN is silently ignored.
- Pop:
  - req = 2 if jmp2, else 1 if jmp1, else 0. jmp1 and jmp2 together count as 2.
  - pop = min(req, complete), using complete before this cycle's increment.
  - If req>complete, set underflow.
  - head←head+pop mod LINE_NUM.
  - complete←complete+inc−pop, with simultaneous write-completion and pop allowed.
  - Pops are honoured in RUN and DRAIN.
- Outputs:
  - fifoNum = complete + (ramAddrIn!=0), registered-state derived. It never exceeds LINE_NUM, because ramAddrIn==0 whenever complete==LINE_NUM.
  - rdBank0=head; rdBank1=head+1 mod LINE_NUM. The head wraps naturally.
- Width rules:
  - All bank arithmetic is modulo LINE_NUM.
  - lineCnt is ADDRESS_WIDTH wide and compared against inYNum.
  - No other saturation is needed.

Test Plan:
1. Reset held 3 cycles with dInEn=1 → all outputs at reset values, rdBank1=1, state IDLE, no ramWrEn.
2. inXNum=8, inYNum=6; inVS plus 8 pixels → ramAddrIn 0..7 on bank 0, then fifoNum=1, ramWrBank=1. 3 more pixels → fifoNum=2, ramAddrIn=3.
3. Fill 4 full lines with no pops → inReady=0, fifoNum=4. One more dInEn → overflow=1, ramWrEn=0, pointers unchanged.
4. From scenario 3, jmp2 → next cycle fifoNum=2, rdBank0=2, rdBank1=3, inReady=1.
5. From fresh frame, jmp1 with complete=0 → underflow=1, rdBank0 stays 0. Also: jmp1 on the same cycle a line completes with complete=1 → complete stays 1, head+1.
6. Write 6 lines with pops keeping space → DRAIN, inReady=0.
   - head at 3, jmp2 → rdBank0=1, rdBank1=2 (wrap).
   - inVS with dInEn → next cycle fifoNum=1, ramAddrIn=1, state RUN.
